// File: rtl/axi4_lite_arbiter.sv
// Two-requester (IFU read-only, LSU read/write) arbiter in front of a single
// AXI4-lite master user port; one outstanding transaction at a time.
module axi4_lite_arbiter #(
    parameter bit FAIR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_done,

    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_resp,
    output logic        lsu_done,

    output logic        m_ren,
    output logic        m_wen,
    output logic [31:0] m_raddr,
    output logic [31:0] m_waddr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wmask,
    output logic        m_user_ready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic [1:0]  m_wresp,
    input  logic        m_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_q,  last_d;
    logic   we_q,    we_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IFU;
            last_q  <= OWN_IFU;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        case (state_q)
            IDLE: begin
                if (ifu_req || lsu_req) begin
                    state_d = ISSUE;
                    if (ifu_req && lsu_req)
                        owner_d = FAIR ? ~last_q : OWN_LSU;
                    else
                        owner_d = lsu_req ? OWN_LSU : OWN_IFU;
                    // direction is frozen here; later lsu_we changes are ignored
                    we_d = (owner_d == OWN_LSU) && lsu_we;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (m_done) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic busy;
    logic in_wait;
    logic sel_lsu;

    always_comb begin
        busy    = (state_q == ISSUE) || (state_q == WAIT);
        in_wait = (state_q == WAIT);
        sel_lsu = busy && (owner_q == OWN_LSU);

        m_ren        = (state_q == ISSUE) && !we_q;
        m_wen        = (state_q == ISSUE) &&  we_q;
        m_user_ready = in_wait;

        m_raddr = 32'd0;
        if (busy) m_raddr = sel_lsu ? lsu_addr : ifu_addr;
        m_waddr = m_raddr;
        m_wdata = sel_lsu ? lsu_wdata : 32'd0;
        m_wmask = sel_lsu ? lsu_wmask : 4'd0;

        ifu_done = in_wait && m_done && (owner_q == OWN_IFU);
        lsu_done = in_wait && m_done && (owner_q == OWN_LSU);

        // data paths are transparent except while reset holds every output low
        ifu_rdata = rst ? 32'd0 : m_rdata;
        lsu_rdata = rst ? 32'd0 : m_rdata;
        ifu_rresp = rst ? 2'd0  : m_rresp;
        lsu_resp  = rst ? 2'd0  : (we_q ? m_wresp : m_rresp);
    end

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Scoreboard bench: a FAIR=1 and a FAIR=0 instance share stimulus; a small
// master model answers whichever instance is selected.
module tb_axi4_lite_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        ifu_req, lsu_req, lsu_we;
    logic [31:0] ifu_addr, lsu_addr, lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic [31:0] m_rdata = 32'hA5A5_0001;
    logic [1:0]  m_rresp, m_wresp;
    logic        m_done = 1'b0;

    logic [31:0] a_ifu_rdata, a_lsu_rdata, a_raddr, a_waddr, a_wdata;
    logic [1:0]  a_ifu_rresp, a_lsu_resp;
    logic [3:0]  a_wmask;
    logic        a_ifu_done, a_lsu_done, a_ren, a_wen, a_ready;
    logic [31:0] b_ifu_rdata, b_lsu_rdata, b_raddr, b_waddr, b_wdata;
    logic [1:0]  b_ifu_rresp, b_lsu_resp;
    logic [3:0]  b_wmask;
    logic        b_ifu_done, b_lsu_done, b_ren, b_wen, b_ready;

    axi4_lite_arbiter #(.FAIR(1'b1)) dut_a (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_rdata(a_ifu_rdata),
        .ifu_rresp(a_ifu_rresp), .ifu_done(a_ifu_done),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_rdata(a_lsu_rdata), .lsu_resp(a_lsu_resp), .lsu_done(a_lsu_done),
        .m_ren(a_ren), .m_wen(a_wen), .m_raddr(a_raddr), .m_waddr(a_waddr),
        .m_wdata(a_wdata), .m_wmask(a_wmask), .m_user_ready(a_ready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_wresp(m_wresp), .m_done(m_done)
    );

    axi4_lite_arbiter #(.FAIR(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_rdata(b_ifu_rdata),
        .ifu_rresp(b_ifu_rresp), .ifu_done(b_ifu_done),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_rdata(b_lsu_rdata), .lsu_resp(b_lsu_resp), .lsu_done(b_lsu_done),
        .m_ren(b_ren), .m_wen(b_wen), .m_raddr(b_raddr), .m_waddr(b_waddr),
        .m_wdata(b_wdata), .m_wmask(b_wmask), .m_user_ready(b_ready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_wresp(m_wresp), .m_done(m_done)
    );

    logic sel = 1'b0;
    logic [31:0] s_ifu_rdata, s_lsu_rdata, s_raddr, s_waddr, s_wdata;
    logic [1:0]  s_ifu_rresp, s_lsu_resp;
    logic [3:0]  s_wmask;
    logic        s_ifu_done, s_lsu_done, s_ren, s_wen, s_ready;

    assign s_ifu_rdata = sel ? b_ifu_rdata : a_ifu_rdata;
    assign s_lsu_rdata = sel ? b_lsu_rdata : a_lsu_rdata;
    assign s_raddr     = sel ? b_raddr     : a_raddr;
    assign s_waddr     = sel ? b_waddr     : a_waddr;
    assign s_wdata     = sel ? b_wdata     : a_wdata;
    assign s_ifu_rresp = sel ? b_ifu_rresp : a_ifu_rresp;
    assign s_lsu_resp  = sel ? b_lsu_resp  : a_lsu_resp;
    assign s_wmask     = sel ? b_wmask     : a_wmask;
    assign s_ifu_done  = sel ? b_ifu_done  : a_ifu_done;
    assign s_lsu_done  = sel ? b_lsu_done  : a_lsu_done;
    assign s_ren       = sel ? b_ren       : a_ren;
    assign s_wen       = sel ? b_wen       : a_wen;
    assign s_ready     = sel ? b_ready     : a_ready;

    // requesters stay asserted until their completed count reaches the goal
    int ifu_goal = 0, ifu_n = 0, lsu_goal = 0, lsu_n = 0;
    assign ifu_req = (ifu_n < ifu_goal);
    assign lsu_req = (lsu_n < lsu_goal);

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h @%0t", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          own;   // 1 = LSU
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } exp_t;
    exp_t sb[$];

    task automatic push(input bit own, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask);
        exp_t e;
        e.own = own; e.we = we; e.addr = addr; e.wdata = wdata; e.wmask = wmask;
        sb.push_back(e);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // master model: done arrives lat cycles after the start pulse
    int lat = 3;
    bit spur = 1'b0;
    bit mbusy = 1'b0;
    int mcnt = 0;
    always @(negedge clk) begin
        m_done = spur;
        if (rst) mbusy = 1'b0;
        else if (mbusy) begin
            if (mcnt <= 1) begin
                m_done  = 1'b1;
                m_rdata = $urandom;
                mbusy   = 1'b0;
            end else mcnt--;
        end else if (s_ren || s_wen) begin
            mbusy = 1'b1;
            mcnt  = lat;
        end
    end

    int iss_n = 0, iss_cyc = -100, done_cyc = -100;
    bit prev_iss = 1'b0;
    bit b2b = 1'b0;

    always @(negedge clk) begin
        #1;
        if (rst) prev_iss = 1'b0;
        else begin
            if (s_ren || s_wen) begin
                chk("excl", 32'(s_ren & s_wen), 32'd0);
                chk("iss_len", 32'(prev_iss), 32'd0);
                chk("rdy_iss", 32'(s_ready), 32'd0);
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spur_iss: got issue want none @%0t", $time);
                end else begin
                    chk("iss_dir", 32'(s_wen), 32'(sb[0].we));
                    chk("iss_raddr", s_raddr, sb[0].addr);
                    chk("iss_waddr", s_waddr, sb[0].addr);
                    if (sb[0].we) begin
                        chk("iss_wdata", s_wdata, sb[0].wdata);
                        chk("iss_wmask", 32'(s_wmask), 32'(sb[0].wmask));
                    end
                    if (b2b) chk("b2b_gap", 32'(cyc - done_cyc), 32'd2);
                end
                iss_n++;
                iss_cyc = cyc;
            end
            prev_iss = s_ren || s_wen;
            if (s_ifu_done || s_lsu_done) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexp_done: got ifu=%0b lsu=%0b want none @%0t",
                             s_ifu_done, s_lsu_done, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_own", 32'(s_lsu_done), 32'(e.own));
                    chk("done_both", 32'(s_ifu_done & s_lsu_done), 32'd0);
                    chk("done_rdy", 32'(s_ready), 32'd1);
                    chk("rdata", e.own ? s_lsu_rdata : s_ifu_rdata, m_rdata);
                    chk("resp", 32'(e.own ? s_lsu_resp : s_ifu_rresp),
                        32'((e.own && e.we) ? m_wresp : m_rresp));
                end
                if (s_lsu_done) lsu_n++;
                if (s_ifu_done) ifu_n++;
                done_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || mbusy) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) begin
            total++; bad++;
            $display("FAIL %s_timeout: got %0d pending want 0", tag, sb.size());
        end
        repeat (2) step();
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!s_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL %s_timeout: got no WAIT want WAIT", tag);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ren"},   32'(s_ren), 32'd0);
        chk({tag, "_wen"},   32'(s_wen), 32'd0);
        chk({tag, "_rdy"},   32'(s_ready), 32'd0);
        chk({tag, "_raddr"}, s_raddr, 32'd0);
        chk({tag, "_waddr"}, s_waddr, 32'd0);
        chk({tag, "_wdata"}, s_wdata, 32'd0);
        chk({tag, "_wmask"}, 32'(s_wmask), 32'd0);
        chk({tag, "_irdata"}, s_ifu_rdata, 32'd0);
        chk({tag, "_irresp"}, 32'(s_ifu_rresp), 32'd0);
        chk({tag, "_idone"}, 32'(s_ifu_done), 32'd0);
        chk({tag, "_lrdata"}, s_lsu_rdata, 32'd0);
        chk({tag, "_lresp"}, 32'(s_lsu_resp), 32'd0);
        chk({tag, "_ldone"}, 32'(s_lsu_done), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, i0, d0, n;
        ifu_addr = 32'd0; lsu_addr = 32'd0; lsu_wdata = 32'd0; lsu_wmask = 4'd0;
        lsu_we = 1'b0; m_rresp = 2'b01; m_wresp = 2'b10;
        repeat (2) step();
        check_zero("rst");
        rst = 1'b0;
        step();

        // single IFU read, master done 3 cycles after m_ren
        lat = 3;
        ifu_addr = 32'h8000_0000;
        push(1'b0, 1'b0, 32'h8000_0000, 32'd0, 4'd0);
        t0 = cyc; i0 = iss_n; d0 = ifu_n;
        ifu_goal++;
        drain("ifu1");
        chk("ifu1_ren_cnt", 32'(iss_n - i0), 32'd1);
        chk("ifu1_ren_cyc", 32'(iss_cyc - t0), 32'd1);
        chk("ifu1_done_lat", 32'(done_cyc - iss_cyc), 32'd3);
        chk("ifu1_done_cnt", 32'(ifu_n - d0), 32'd1);

        // single LSU write with OKAY wresp
        lat = 2; m_wresp = 2'b00; m_rresp = 2'b01;
        lsu_we = 1'b1; lsu_addr = 32'h0000_1000; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        push(1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
        i0 = iss_n; d0 = lsu_n;
        lsu_goal++;
        drain("lsuw");
        chk("lsuw_wen_cnt", 32'(iss_n - i0), 32'd1);
        chk("lsuw_done_cnt", 32'(lsu_n - d0), 32'd1);

        // minimum latency IFU read
        lat = 1; lsu_we = 1'b0; m_wresp = 2'b10;
        ifu_addr = 32'h0000_0040;
        push(1'b0, 1'b0, 32'h0000_0040, 32'd0, 4'd0);
        t0 = cyc;
        ifu_goal++;
        drain("minlat");
        chk("minlat_done_cyc", 32'(done_cyc - t0), 32'd2);

        // FAIR=1 tie: last owner is IFU so LSU goes first, then alternate
        lat = 2;
        ifu_addr = 32'h0000_3000; lsu_addr = 32'h0000_2000; lsu_we = 1'b0;
        push(1'b1, 1'b0, 32'h0000_2000, 32'd0, 4'd0);
        push(1'b0, 1'b0, 32'h0000_3000, 32'd0, 4'd0);
        push(1'b1, 1'b0, 32'h0000_2000, 32'd0, 4'd0);
        push(1'b0, 1'b0, 32'h0000_3000, 32'd0, 4'd0);
        i0 = iss_n; d0 = ifu_n + lsu_n;
        ifu_goal += 2; lsu_goal += 2;
        n = 0;
        while (iss_n == i0 && n < 20) begin step(); n++; end
        b2b = 1'b1;
        drain("fair");
        b2b = 1'b0;
        chk("fair_grants", 32'(iss_n - i0), 32'd4);
        chk("fair_dones", 32'(ifu_n + lsu_n - d0), 32'd4);

        // spurious m_done while idle
        i0 = iss_n; d0 = ifu_n + lsu_n;
        @(posedge clk); spur = 1'b1;
        @(posedge clk); spur = 1'b0;
        repeat (3) step();
        chk("spur_iss", 32'(iss_n - i0), 32'd0);
        chk("spur_done", 32'(ifu_n + lsu_n - d0), 32'd0);

        // lsu_we flipped during WAIT: response follows latched direction
        lat = 4; m_rresp = 2'b01; m_wresp = 2'b10;
        lsu_we = 1'b1; lsu_addr = 32'h0000_1100; lsu_wdata = 32'h1234_5678; lsu_wmask = 4'h3;
        push(1'b1, 1'b1, 32'h0000_1100, 32'h1234_5678, 4'h3);
        lsu_goal++;
        step();
        wait_ready("tgl_w");
        lsu_we = 1'b0;
        drain("tgl_w");
        lsu_addr = 32'h0000_1200;
        push(1'b1, 1'b0, 32'h0000_1200, 32'd0, 4'd0);
        lsu_goal++;
        step();
        wait_ready("tgl_r");
        lsu_we = 1'b1;
        drain("tgl_r");
        lsu_we = 1'b0;

        // reset in WAIT of an LSU read abandons it with no done
        lat = 8; lsu_addr = 32'h0000_4000; m_rresp = 2'b11;
        push(1'b1, 1'b0, 32'h0000_4000, 32'd0, 4'd0);
        d0 = lsu_n;
        lsu_goal++;
        step();
        wait_ready("rstw");
        #2 rst = 1'b1;
        #1 check_zero("rstmid");
        sb.delete();
        lsu_goal = lsu_n;
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();
        chk("rstmid_no_done", 32'(lsu_n - d0), 32'd0);
        m_rresp = 2'b01;

        // normal IFU read after reset
        lat = 2; ifu_addr = 32'h0000_5000;
        push(1'b0, 1'b0, 32'h0000_5000, 32'd0, 4'd0);
        d0 = ifu_n;
        ifu_goal++;
        drain("postrst");
        chk("postrst_done", 32'(ifu_n - d0), 32'd1);

        // FAIR=0: LSU wins every tie, IFU served only once LSU stops
        rst = 1'b1; sel = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        lat = 2; lsu_addr = 32'h0000_6000; ifu_addr = 32'h0000_7000; lsu_we = 1'b0;
        push(1'b1, 1'b0, 32'h0000_6000, 32'd0, 4'd0);
        push(1'b1, 1'b0, 32'h0000_6000, 32'd0, 4'd0);
        push(1'b1, 1'b0, 32'h0000_6000, 32'd0, 4'd0);
        push(1'b0, 1'b0, 32'h0000_7000, 32'd0, 4'd0);
        i0 = ifu_n; d0 = lsu_n;
        lsu_goal += 3; ifu_goal += 1;
        drain("fix");
        chk("fix_lsu_dones", 32'(lsu_n - d0), 32'd3);
        chk("fix_ifu_dones", 32'(ifu_n - i0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
